// File: rtl/dma_copy.sv
// Single-channel word-copy DMA: register device port plus a bus host port.
// Copies LEN words from SRC to DST in ascending order, one transaction at a time.
module dma_copy #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    dev_req_i,
   input  logic                    dev_we_i,
   input  logic [3:0]              dev_be_i,
   input  logic [AddressWidth-1:0] dev_addr_i,
   input  logic [DataWidth-1:0]    dev_wdata_i,
   output logic                    dev_rvalid_o,
   output logic [DataWidth-1:0]    dev_rdata_o,
   output logic                    dev_err_o,
   output logic                    host_req_o,
   input  logic                    host_gnt_i,
   output logic [AddressWidth-1:0] host_addr_o,
   output logic                    host_we_o,
   output logic [3:0]              host_be_o,
   output logic [DataWidth-1:0]    host_wdata_o,
   input  logic                    host_rvalid_i,
   input  logic [DataWidth-1:0]    host_rdata_i,
   input  logic                    host_err_i,
   output logic                    irq_o
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN
   } state_e;

   state_e                  state_q;
   logic [AddressWidth-1:0] src_q, dst_q;
   logic [AddressWidth-1:0] cur_src, cur_dst;
   logic [AddressWidth-1:0] src_nxt, dst_nxt;
   logic [DataWidth-1:0]    len_q, remaining;
   logic                    ie_q, done_q, err_q, fail_q;
   logic                    busy, wr_ok, start;
   logic [1:0]              sel;
   logic [DataWidth-1:0]    rd_mux;
   logic                    unused_addr;

   assign busy      = (state_q != IDLE);
   assign sel       = dev_addr_i[3:2];
   assign wr_ok     = dev_req_i & dev_we_i & (dev_be_i == 4'hF);
   assign start     = wr_ok & (sel == 2'd3) & dev_wdata_i[0] & ~busy;
   assign src_nxt   = cur_src + AddressWidth'(4);
   assign dst_nxt   = cur_dst + AddressWidth'(4);
   assign host_be_o = 4'hF;
   assign unused_addr = ^{dev_addr_i[AddressWidth-1:4], dev_addr_i[1:0]};

   always_comb begin
      rd_mux = '0;
      unique case (sel)
         2'd0: rd_mux = DataWidth'(src_q);
         2'd1: rd_mux = DataWidth'(dst_q);
         2'd2: rd_mux = len_q;
         2'd3: rd_mux = DataWidth'({ie_q, err_q, done_q, busy});
      endcase
   end

   // Register writes come first so that flag sets from the FSM win.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         cur_src      <= '0;
         cur_dst      <= '0;
         remaining    <= '0;
         ie_q         <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         fail_q       <= 1'b0;
         dev_rvalid_o <= 1'b0;
         dev_rdata_o  <= '0;
         dev_err_o    <= 1'b0;
         host_req_o   <= 1'b0;
         host_we_o    <= 1'b0;
         host_addr_o  <= '0;
         host_wdata_o <= '0;
         irq_o        <= 1'b0;
      end else begin
         dev_rvalid_o <= dev_req_i;
         dev_err_o    <= 1'b0;
         dev_rdata_o  <= '0;
         if (dev_req_i && !dev_we_i)
            dev_rdata_o <= rd_mux;
         if (wr_ok) begin
            unique case (sel)
               2'd0: if (busy) dev_err_o <= 1'b1;
                     else src_q <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
               2'd1: if (busy) dev_err_o <= 1'b1;
                     else dst_q <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
               2'd2: if (busy) dev_err_o <= 1'b1;
                     else len_q <= dev_wdata_i;
               2'd3: begin
                  ie_q <= dev_wdata_i[1];
                  if (dev_wdata_i[2]) begin
                     done_q <= 1'b0;
                     err_q  <= 1'b0;
                  end
               end
            endcase
         end
         irq_o <= done_q & ie_q;

         unique case (state_q)
            IDLE: if (start) begin
               cur_src   <= src_q;
               cur_dst   <= dst_q;
               remaining <= len_q;
               done_q    <= 1'b0;
               err_q     <= 1'b0;
               fail_q    <= 1'b0;
               if (len_q == '0) begin
                  state_q <= FIN;
               end else begin
                  state_q     <= RD_REQ;
                  host_req_o  <= 1'b1;
                  host_we_o   <= 1'b0;
                  host_addr_o <= src_q;
               end
            end
            RD_REQ: if (host_gnt_i) begin
               host_req_o <= 1'b0;
               state_q    <= RD_WAIT;
            end
            RD_WAIT: if (host_rvalid_i) begin
               if (host_err_i) begin
                  err_q   <= 1'b1;
                  fail_q  <= 1'b1;
                  state_q <= FIN;
               end else begin
                  host_wdata_o <= host_rdata_i;
                  host_req_o   <= 1'b1;
                  host_we_o    <= 1'b1;
                  host_addr_o  <= cur_dst;
                  state_q      <= WR_REQ;
               end
            end
            WR_REQ: if (host_gnt_i) begin
               host_req_o <= 1'b0;
               state_q    <= WR_WAIT;
            end
            WR_WAIT: if (host_rvalid_i) begin
               if (host_err_i) begin
                  err_q   <= 1'b1;
                  fail_q  <= 1'b1;
                  state_q <= FIN;
               end else begin
                  cur_src   <= src_nxt;
                  cur_dst   <= dst_nxt;
                  remaining <= remaining - DataWidth'(1);
                  if (remaining == DataWidth'(1)) begin
                     state_q <= FIN;
                  end else begin
                     host_req_o  <= 1'b1;
                     host_we_o   <= 1'b0;
                     host_addr_o <= src_nxt;
                     state_q     <= RD_REQ;
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b1;
               if (fail_q) err_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
